// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty path: duty width, full-scale
// value, slew FSM states and the command clamp helper.
package pwm_pkg;

  localparam int DUTY_W = 10;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SHDN
  } state_e;

  // Returns v untouched when limiting is off, otherwise v bounded to [lo, hi].
  function automatic logic [DUTY_W-1:0] clamp_duty(
    input logic [DUTY_W-1:0] v,
    input logic [DUTY_W-1:0] lo,
    input logic [DUTY_W-1:0] hi,
    input logic              limit_on
  );
    if (!limit_on) return v;
    if (v < lo)    return lo;
    if (v > hi)    return hi;
    return v;
  endfunction

endpackage

// File: rtl/duty_slew_if.sv
// Duty command valid/ready channel between a command source (master) and the
// duty slew limiter (slave).
interface duty_slew_if;
  import pwm_pkg::*;

  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_vld;
  logic              cmd_rdy;

  modport master (output cmd_duty, output cmd_vld, input  cmd_rdy);
  modport slave  (input  cmd_duty, input  cmd_vld, output cmd_rdy);

endinterface

// File: rtl/duty_step.sv
// One slew step: moves duty toward dest by at most step, landing exactly on
// dest when it is within reach. 11-bit arithmetic so nothing wraps.
module duty_step
  import pwm_pkg::*;
(
  input  logic [DUTY_W-1:0] duty_i,
  input  logic [DUTY_W-1:0] dest_i,
  input  logic [DUTY_W-1:0] step_i,
  output logic [DUTY_W-1:0] duty_o
);

  logic [DUTY_W:0] up_gap;
  logic [DUTY_W:0] dn_gap;
  logic [DUTY_W:0] up_val;
  logic [DUTY_W:0] dn_val;

  always_comb begin
    up_gap = {1'b0, dest_i} - {1'b0, duty_i};
    dn_gap = {1'b0, duty_i} - {1'b0, dest_i};
    up_val = {1'b0, duty_i} + {1'b0, step_i};
    dn_val = {1'b0, duty_i} - {1'b0, step_i};
    duty_o = duty_i;
    if (dest_i > duty_i) begin
      // Saturation and floor below are defensive; the gap test already bounds them.
      if (up_gap > {1'b0, step_i})
        duty_o = (up_val > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_val[DUTY_W-1:0];
      else
        duty_o = dest_i;
    end else if (dest_i < duty_i) begin
      if (dn_gap > {1'b0, step_i})
        duty_o = dn_val[DUTY_W] ? '0 : dn_val[DUTY_W-1:0];
      else
        duty_o = dest_i;
    end
  end

endmodule

// File: rtl/duty_slew.sv
// Duty slew limiter: tracks commanded duty at most STEP counts per PWM period,
// ramps to 0 when en is low. Define DUTY_LIMIT_EN to clamp commands to [MIN_DUTY, MAX_DUTY].
module duty_slew
  import pwm_pkg::*;
#(
  parameter int unsigned       STEP     = 8,
  parameter logic [DUTY_W-1:0] MIN_DUTY = 10'h000,
  parameter logic [DUTY_W-1:0] MAX_DUTY = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              period_tick,
  duty_slew_if.slave        cmd,
  output logic [DUTY_W-1:0] duty,
  output logic              at_target
);

`ifdef DUTY_LIMIT_EN
  localparam logic LIMIT_ON = 1'b1;
`else
  localparam logic LIMIT_ON = 1'b0;
`endif

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              at_target_q, at_target_d;
  logic [DUTY_W-1:0] dest;
  logic [DUTY_W-1:0] stepped;
  logic              accept;

  assign cmd.cmd_rdy = en & (state_q != SHDN);
  assign accept      = cmd.cmd_vld & cmd.cmd_rdy;
  assign dest        = (state_q == SHDN) ? '0 : target_q;

  duty_step u_step (
    .duty_i (duty_q),
    .dest_i (dest),
    .step_i (STEP_V),
    .duty_o (stepped)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    duty_d   = duty_q;
    target_d = target_q;
    state_d  = state_q;

    // A same-cycle tick steps toward the old target; the new one applies from the next tick.
    if (period_tick) duty_d = stepped;
    if (accept)      target_d = clamp_duty(cmd.cmd_duty, MIN_DUTY, MAX_DUTY, LIMIT_ON);

    unique case (state_q)
      IDLE: begin
        if (!en)                     state_d = SHDN;
        else if (duty_d != target_d) state_d = RAMP;
      end
      RAMP: begin
        if (!en)                     state_d = SHDN;
        else if (duty_d == target_d) state_d = IDLE;
      end
      SHDN: begin
        if (en) state_d = (duty_d == target_d) ? IDLE : RAMP;
      end
      default: state_d = IDLE;
    endcase

    at_target_d = (state_d != SHDN) && (duty_d == target_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      duty_q      <= '0;
      target_q    <= '0;
      state_q     <= IDLE;
      at_target_q <= 1'b1;
    end else begin
      duty_q      <= duty_d;
      target_q    <= target_d;
      state_q     <= state_d;
      at_target_q <= at_target_d;
    end
  end

  assign duty      = duty_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_duty_slew.sv
// Self-checking bench for duty_slew: directed scenarios plus random traffic,
// all compared every cycle against a per-period arithmetic reference model.
module tb_duty_slew;
  import pwm_pkg::*;

  localparam int unsigned       STEP  = 8;
  localparam logic [DUTY_W-1:0] MIN_D = 10'h010;
  localparam logic [DUTY_W-1:0] MAX_D = 10'h300;

  logic              clk;
  logic              rst;
  logic              en;
  logic              period_tick;
  logic [DUTY_W-1:0] duty;
  logic              at_target;

  duty_slew_if cmd_if ();

  duty_slew #(
    .STEP     (STEP),
    .MIN_DUTY (MIN_D),
    .MAX_DUTY (MAX_D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period_tick (period_tick),
    .cmd         (cmd_if.slave),
    .duty        (duty),
    .at_target   (at_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: duty value, target value, and whether we are shut down.
  int m_duty   = 0;
  int m_target = 0;
  bit m_shdn   = 1'b0;
  bit m_valid  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lim(input int v);
`ifdef DUTY_LIMIT_EN
    if (v < int'(MIN_D)) return int'(MIN_D);
    if (v > int'(MAX_D)) return int'(MAX_D);
`endif
    return v;
  endfunction

  // Move cur toward dst by a signed delta bounded to +/-STEP.
  function automatic int toward(input int cur, input int dst);
    int d;
    d = dst - cur;
    if (d >  int'(STEP)) d =  int'(STEP);
    if (d < -int'(STEP)) d = -int'(STEP);
    return cur + d;
  endfunction

  // One clock: drive inputs, check the combinational ready, clock, update model, check outputs.
  task automatic cyc(input bit t, input bit v, input logic [DUTY_W-1:0] c, input bit r);
    bit acc;
    rst                = r;
    period_tick        = t;
    cmd_if.cmd_vld     = v;
    cmd_if.cmd_duty    = c;
    #1;
    if (m_valid) check("cmd_rdy", {31'b0, cmd_if.cmd_rdy}, {31'b0, en && !m_shdn});
    @(posedge clk);
    if (rst) begin
      m_duty   = 0;
      m_target = 0;
      m_shdn   = 1'b0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      acc = cmd_if.cmd_vld && en && !m_shdn;
      if (period_tick) m_duty = toward(m_duty, m_shdn ? 0 : m_target);
      if (acc)         m_target = lim(int'(cmd_if.cmd_duty));
      m_shdn = !en;
    end
    #1;
    if (m_valid) begin
      check("duty", {22'b0, duty}, m_duty);
      check("at_target", {31'b0, at_target}, {31'b0, !m_shdn && (m_duty == m_target)});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      idle(gap - 1);
      cyc(1'b1, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic send(input logic [DUTY_W-1:0] c);
    cyc(1'b0, 1'b1, c, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DUTY_W-1:0] rc;
    en = 1'b1;
    rst = 1'b1;
    period_tick = 1'b0;
    cmd_if.cmd_vld = 1'b0;
    cmd_if.cmd_duty = '0;

    // Reset, then reset again in the middle of a ramp.
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    check("rst_duty", {22'b0, duty}, 32'h0);
    check("rst_at_target", {31'b0, at_target}, 32'h1);
    check("rst_cmd_rdy", {31'b0, cmd_if.cmd_rdy}, 32'h1);
    cyc(1'b0, 1'b0, '0, 1'b0);
    send(10'h100);
    ticks(3, 4);
    check("midramp_duty", {22'b0, duty}, 32'h018);
    cyc(1'b1, 1'b0, '0, 1'b1);
    check("midramp_rst_duty", {22'b0, duty}, 32'h0);
    check("midramp_rst_at", {31'b0, at_target}, 32'h1);

    // Slow ramp to 0x040 with one tick per 1024 cycles.
    send(10'h040);
    for (int k = 1; k <= 8; k++) begin
      ticks(1, 1024);
      check("ramp40_duty", {22'b0, duty}, 32'(8 * k));
      if (k == 7) check("ramp40_at_early", {31'b0, at_target}, 32'h0);
    end
    check("ramp40_at", {31'b0, at_target}, 32'h1);

    // Partial step, climb to full scale, descend to zero.
    send(10'h045);
    ticks(1, 4);
    check("partial_duty", {22'b0, duty}, 32'(lim(10'h045)));
    send(10'h3FF);
    ticks(130, 4);
    check("top_duty", {22'b0, duty}, 32'(lim(10'h3FF)));
    check("top_at", {31'b0, at_target}, 32'h1);
    send(10'h000);
    ticks(130, 4);
    check("bottom_duty", {22'b0, duty}, 32'(lim(0)));

    // Retarget in the same cycle as a tick: that tick still uses the old target.
    cyc(1'b0, 1'b0, '0, 1'b1);
    send(10'h100);
    ticks(4, 4);
    check("retarget_pre", {22'b0, duty}, 32'h020);
    idle(3);
    cyc(1'b1, 1'b1, 10'h010, 1'b0);
    check("retarget_tick", {22'b0, duty}, 32'h028);
    for (int k = 0; k < 3; k++) begin
      ticks(1, 4);
      check("retarget_down", {22'b0, duty}, 32'(32'h020 - 8 * k));
    end
    check("retarget_at", {31'b0, at_target}, 32'h1);

    // Soft shutdown, ignored command, recovery.
    send(10'h020);
    ticks(2, 4);
    check("shdn_pre_duty", {22'b0, duty}, 32'h020);
    check("shdn_pre_at", {31'b0, at_target}, 32'h1);
    en = 1'b0;
    #1;
    check("shdn_rdy_same_cycle", {31'b0, cmd_if.cmd_rdy}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      ticks(1, 4);
      check("shdn_duty", {22'b0, duty}, 32'(32'h020 - 8 * k));
    end
    cyc(1'b0, 1'b1, 10'h3FF, 1'b0);
    idle(2);
    en = 1'b1;
    ticks(4, 4);
    check("recover_duty", {22'b0, duty}, 32'h020);
    check("recover_at", {31'b0, at_target}, 32'h1);

`ifdef DUTY_LIMIT_EN
    send(10'h3FF);
    ticks(110, 4);
    check("limit_hi", {22'b0, duty}, {22'b0, MAX_D});
    send(10'h004);
    ticks(110, 4);
    check("limit_lo", {22'b0, duty}, {22'b0, MIN_D});
    en = 1'b0;
    ticks(4, 4);
    check("limit_shdn_zero", {22'b0, duty}, 32'h0);
    en = 1'b1;
    idle(2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 63) == 0) en = ~en;
      case ($urandom_range(0, 7))
        0:       rc = '0;
        1:       rc = 10'h3FF;
        2:       rc = DUTY_W'(m_duty);
        default: rc = DUTY_W'($urandom);
      endcase
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, rc,
          $urandom_range(0, 999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
